// File: rtl/servant_gpio_pkg.sv
// -----------------------------------------------------------------------------
// servant_gpio_pkg
// Shared constants for the multi-channel servant GPIO block.
//   ADR_DATA / ADR_MODE      : register select values on i_wb_adr
//   MODE_DIRECT / MODE_STRETCH : per-channel mode bit encodings
//   MAX_WIDTH                : widest legal channel count (one bus word)
// -----------------------------------------------------------------------------
package servant_gpio_pkg;

  localparam logic ADR_DATA     = 1'b0;
  localparam logic ADR_MODE     = 1'b1;

  localparam logic MODE_DIRECT  = 1'b0;
  localparam logic MODE_STRETCH = 1'b1;

  localparam int   MAX_WIDTH    = 32;

endpackage

// File: rtl/servant_gpio_stretch.sv
// -----------------------------------------------------------------------------
// servant_gpio_stretch
// Per-channel activity stretcher: turns a one-cycle edge strobe into a pulse
// that is 2^STRETCH_W-1 cycles long, long enough to be seen on an LED.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   en       in   channel is in stretch mode (next-state mode bit)
//   edge_det in   data bit of this channel changed
//   active   out  pulse output, high while the counter is non-zero
// -----------------------------------------------------------------------------
module servant_gpio_stretch #(
  parameter int STRETCH_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic edge_det,
  output logic active
);

  localparam logic [STRETCH_W-1:0] CNT_ONE = STRETCH_W'(1);

  logic [STRETCH_W-1:0] cnt_q;
  logic [STRETCH_W-1:0] cnt_d;

  // Leaving stretch mode clears the counter on the same edge; an edge reloads
  // (retriggers) the full count; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (edge_det) begin
      cnt_d = '1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/servant_gpio_multi.sv
// -----------------------------------------------------------------------------
// servant_gpio_multi
// Wishbone-slave GPIO output block with WIDTH channels. Each channel either
// drives its DATA bit directly (UART TX, plain LED) or stretches every edge
// of its DATA bit into a visible LED pulse.
// Ports:
//   wb_clk       in   system clock
//   wb_rst_n     in   synchronous active-low reset
//   i_wb_adr     in   register select: 0 = DATA, 1 = MODE
//   i_wb_dat     in   write data (low WIDTH bits used)
//   i_wb_we      in   write enable
//   i_wb_cyc     in   bus cycle request
//   o_wb_rdt     out  read data, zero-extended, held until the next access
//   o_wb_ack     out  single-cycle acknowledge
//   o_gpio       out  channel outputs
//   o_heartbeat  out  heartbeat LED
// Optional feature: define SERVANT_GPIO_HEARTBEAT_EN to build a free-running
// heartbeat counter; otherwise o_heartbeat is tied low.
// -----------------------------------------------------------------------------
module servant_gpio_multi
  import servant_gpio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          STRETCH_W = 20,
  parameter logic [31:0] RESET_VAL = 32'h0000_0001,
  parameter int          HB_LOG2   = 24
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  output logic [WIDTH-1:0] o_gpio,
  output logic             o_heartbeat
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || HB_LOG2 < 0) begin : g_bad_cfg
    $fatal(1, "servant_gpio_multi: WIDTH must be 1..32 and HB_LOG2 non-negative");
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mode_q, mode_d;
  logic [WIDTH-1:0] prev_data_q, prev_data_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             access;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] active;

  // An access is accepted on the edge where ack rises; holding cyc high
  // therefore yields an ack every second cycle.
  assign access = i_wb_cyc & ~ack_q;

  always_comb begin
    data_d      = data_q;
    mode_d      = mode_q;
    rdt_d       = rdt_q;
    ack_d       = access;
    prev_data_d = data_q;
    if (access) begin
      rdt_d = '0;
      rdt_d[WIDTH-1:0] = (i_wb_adr == ADR_MODE) ? mode_q : data_q;
      if (i_wb_we) begin
        if (i_wb_adr == ADR_DATA) begin
          data_d = i_wb_dat[WIDTH-1:0];
        end else begin
          mode_d = i_wb_dat[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      data_q      <= RESET_VAL[WIDTH-1:0];
      prev_data_q <= RESET_VAL[WIDTH-1:0];
      mode_q      <= '0;
      ack_q       <= 1'b0;
      rdt_q       <= '0;
    end else begin
      data_q      <= data_d;
      prev_data_q <= prev_data_d;
      mode_q      <= mode_d;
      ack_q       <= ack_d;
      rdt_q       <= rdt_d;
    end
  end

  // A rewrite of an unchanged value leaves DATA equal to prev_data: no edge.
  assign edge_vec = data_q ^ prev_data_q;

  // The stretchers see the next-state mode so that clearing a mode bit zeroes
  // the counter on the very edge that writes MODE.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    servant_gpio_stretch #(
      .STRETCH_W (STRETCH_W)
    ) u_stretch (
      .clk      (wb_clk),
      .rst_n    (wb_rst_n),
      .en       (mode_d[g] == MODE_STRETCH),
      .edge_det (edge_vec[g]),
      .active   (active[g])
    );
  end

  always_comb begin
    o_gpio = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_q[i] == MODE_STRETCH) begin
        o_gpio[i] = active[i];
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;

`ifdef SERVANT_GPIO_HEARTBEAT_EN
  localparam logic [HB_LOG2:0] HB_ONE = (HB_LOG2 + 1)'(1);

  logic [HB_LOG2:0] hb_q, hb_d;

  always_comb begin
    hb_d = hb_q + HB_ONE;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_d;
    end
  end

  assign o_heartbeat = hb_q[HB_LOG2];
`else
  assign o_heartbeat = 1'b0;
`endif

  // Upper write-data bits are ignored when WIDTH < 32.
  logic unused_dat;
  assign unused_dat = ^i_wb_dat;

endmodule

// File: tb/tb_servant_gpio_multi.sv
// -----------------------------------------------------------------------------
// tb_servant_gpio_multi
// Directed bench for servant_gpio_multi with WIDTH=8, STRETCH_W=4, HB_LOG2=3.
// A behavioural model tracks registers and the tick at which each stretch
// pulse ends; a compare process checks every output on every negedge, and
// the directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_servant_gpio_multi;

  localparam int WIDTH     = 8;
  localparam int STRETCH_W = 4;
  localparam int HB_LOG2   = 3;
  localparam int PULSE     = (1 << STRETCH_W) - 1;

  logic              wb_clk   = 1'b0;
  logic              wb_rst_n = 1'b0;
  logic              i_wb_adr = 1'b0;
  logic [31:0]       i_wb_dat = '0;
  logic              i_wb_we  = 1'b0;
  logic              i_wb_cyc = 1'b0;
  logic [31:0]       o_wb_rdt;
  logic              o_wb_ack;
  logic [WIDTH-1:0]  o_gpio;
  logic              o_heartbeat;

  int checks = 0;
  int errors = 0;
  int ack_lat = 0;

  servant_gpio_multi #(
    .WIDTH     (WIDTH),
    .STRETCH_W (STRETCH_W),
    .RESET_VAL (32'h0000_0001),
    .HB_LOG2   (HB_LOG2)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .i_wb_adr    (i_wb_adr),
    .i_wb_dat    (i_wb_dat),
    .i_wb_we     (i_wb_we),
    .i_wb_cyc    (i_wb_cyc),
    .o_wb_rdt    (o_wb_rdt),
    .o_wb_ack    (o_wb_ack),
    .o_gpio      (o_gpio),
    .o_heartbeat (o_heartbeat)
  );

  always #5 wb_clk = ~wb_clk;

  // Model state: register contents, pending edges, and for each channel the
  // tick before which its stretch pulse is visible.
  int               tick = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_mode = '0;
  logic [WIDTH-1:0] m_pend = '0;
  int               m_hi_until [WIDTH];
  logic             m_ack = 1'b0;
  logic [31:0]      m_rdt = '0;
  int               m_hb = 0;
  bit               cmp_en = 1'b0;

  // The model advances once per rising edge using the inputs held stable
  // since the previous falling edge.
  always @(posedge wb_clk) begin
    logic [WIDTH-1:0] new_data;
    logic [WIDTH-1:0] new_mode;
    tick = tick + 1;
    if (!wb_rst_n) begin
      m_data = WIDTH'(32'h1);
      m_mode = '0;
      m_pend = '0;
      m_ack  = 1'b0;
      m_rdt  = '0;
      m_hb   = 0;
      for (int i = 0; i < WIDTH; i++) m_hi_until[i] = 0;
    end else begin
      new_data = m_data;
      new_mode = m_mode;
      if (i_wb_cyc && !m_ack) begin
        m_rdt = i_wb_adr ? 32'(m_mode) : 32'(m_data);
        if (i_wb_we) begin
          if (i_wb_adr) new_mode = i_wb_dat[WIDTH-1:0];
          else          new_data = i_wb_dat[WIDTH-1:0];
        end
        m_ack = 1'b1;
      end else begin
        m_ack = 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (!new_mode[i])   m_hi_until[i] = 0;
        else if (m_pend[i]) m_hi_until[i] = tick + PULSE;
      end
      m_pend = m_data ^ new_data;
      m_data = new_data;
      m_mode = new_mode;
      m_hb   = m_hb + 1;
    end
  end

  function automatic logic [WIDTH-1:0] expGpio();
    logic [WIDTH-1:0] g;
    for (int i = 0; i < WIDTH; i++) begin
      g[i] = m_mode[i] ? (tick < m_hi_until[i]) : m_data[i];
    end
    return g;
  endfunction

  function automatic logic expHeartbeat();
`ifdef SERVANT_GPIO_HEARTBEAT_EN
    return 1'((m_hb >> HB_LOG2) & 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on every falling edge.
  always @(negedge wb_clk) begin
    if (cmp_en) begin
      checkOutput("model_gpio", 32'(o_gpio), 32'(expGpio()));
      checkOutput("model_ack", 32'(o_wb_ack), 32'(m_ack));
      checkOutput("model_rdt", o_wb_rdt, m_rdt);
      checkOutput("model_heartbeat", 32'(o_heartbeat), 32'(expHeartbeat()));
    end
  end

  // One bus access, started at a falling edge; returns at the falling edge
  // where ack is seen, with cyc already dropped.
  task automatic applyStimulus(input logic adr, input logic we, input logic [31:0] dat);
    bit got = 1'b0;
    i_wb_adr = adr;
    i_wb_we  = we;
    i_wb_dat = dat;
    i_wb_cyc = 1'b1;
    ack_lat  = 0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge wb_clk);
      if (o_wb_ack) begin
        got     = 1'b1;
        ack_lat = n + 1;
      end
    end
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    checkOutput("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic countHigh(input int bit_idx, input int cycles, output int hits);
    hits = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge wb_clk);
      if (o_gpio[bit_idx]) hits++;
    end
  endtask

  initial begin
    int hits;
    int gap;
    bit found;
    logic last_hb;

    // Reset held low for three rising edges.
    @(posedge wb_clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    checkOutput("reset_gpio", 32'(o_gpio), 32'h01);
    checkOutput("reset_ack", 32'(o_wb_ack), 32'h0);
    checkOutput("reset_heartbeat", 32'(o_heartbeat), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reset_data_read", o_wb_rdt, 32'h0000_0001);

    // Handshake and write of DATA.
    @(negedge wb_clk);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFA5);
    checkOutput("ack_latency", 32'(ack_lat), 32'd1);
    @(negedge wb_clk);
    checkOutput("ack_single_pulse", 32'(o_wb_ack), 32'h0);
    checkOutput("write_gpio", 32'(o_gpio), 32'hA5);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("data_read", o_wb_rdt, 32'h0000_00A5);

    // Stretch on channel 1.
    @(negedge wb_clk);
    applyStimulus(1'b1, 1'b1, 32'h0000_0002);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mode_read", o_wb_rdt, 32'h0000_0002);
    @(negedge wb_clk);
    applyStimulus(1'b0, 1'b1, 32'h0000_00A7);
    countHigh(1, 30, hits);
    checkOutput("stretch_len", 32'(hits), 32'd15);
    applyStimulus(1'b0, 1'b1, 32'h0000_00A7);
    countHigh(1, 20, hits);
    checkOutput("no_edge_no_pulse", 32'(hits), 32'd0);

    // Retrigger: second edge while the first pulse is still running.
    applyStimulus(1'b0, 1'b1, 32'h0000_00A5);
    repeat (7) @(negedge wb_clk);
    applyStimulus(1'b0, 1'b1, 32'h0000_00A7);
    checkOutput("retrig_still_high", 32'(o_gpio[1]), 32'h1);
    countHigh(1, 30, hits);
    checkOutput("retrig_len", 32'(hits), 32'd15);

    // Mode switch mid-pulse and mode set with a stable data bit.
    applyStimulus(1'b0, 1'b1, 32'h0000_00A5);
    repeat (3) @(negedge wb_clk);
    checkOutput("mid_pulse_high", 32'(o_gpio[1]), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0000);
    checkOutput("mode_clear_gpio", 32'(o_gpio), 32'hA5);
    @(negedge wb_clk);
    applyStimulus(1'b0, 1'b1, 32'h0000_00A7);
    checkOutput("direct_gpio", 32'(o_gpio), 32'hA7);
    repeat (2) @(negedge wb_clk);
    applyStimulus(1'b1, 1'b1, 32'h0000_0002);
    checkOutput("mode_set_gpio", 32'(o_gpio), 32'hA5);
    repeat (2) @(negedge wb_clk);

    // Reset arriving during a pending ack and a running pulse.
    applyStimulus(1'b0, 1'b1, 32'h0000_00A5);
    repeat (3) @(negedge wb_clk);
    i_wb_adr = 1'b0;
    i_wb_we  = 1'b1;
    i_wb_dat = 32'h0000_00FF;
    i_wb_cyc = 1'b1;
    wb_rst_n = 1'b0;
    @(negedge wb_clk);
    checkOutput("rst_pending_ack", 32'(o_wb_ack), 32'h0);
    checkOutput("rst_gpio", 32'(o_gpio), 32'h01);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    checkOutput("post_rst_gpio", 32'(o_gpio), 32'h01);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_mode", o_wb_rdt, 32'h0);

    // Heartbeat.
`ifdef SERVANT_GPIO_HEARTBEAT_EN
    found   = 1'b0;
    last_hb = o_heartbeat;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge wb_clk);
      if (o_heartbeat != last_hb) found = 1'b1;
      last_hb = o_heartbeat;
    end
    checkOutput("hb_first_toggle", 32'(found), 32'd1);
    gap   = 0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge wb_clk);
      gap++;
      if (o_heartbeat != last_hb) found = 1'b1;
    end
    checkOutput("hb_period", 32'(gap), 32'd8);
`else
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge wb_clk);
      if (o_heartbeat) hits++;
    end
    checkOutput("hb_tied_low", 32'(hits), 32'd0);
`endif

    @(negedge wb_clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servant_gpio_multi.md
Name: servant_gpio_multi

Overview:
- Wishbone-slave GPIO output block for the servant SoC, parametrised to WIDTH output channels. Generalises the single-bit `q` GPIO.
- Every channel can run in one of two modes:
  - direct: drives a bit-banged UART TX or a plain LED.
  - activity-stretch: drives a visible LED pulse on every edge of the channel's data bit.
- Sits on the servant data bus beside the timer. Its outputs feed board-level pins such as `o_uart_tx` and `o_led_*`.

Parameters:
- WIDTH, 8, number of output channels; legal range 1..32.
- STRETCH_W, 20, width of the stretch counter. Pulse length is 2^STRETCH_W-1 cycles.
- RESET_VAL, 32'h0000_0001, reset value of the data register; low WIDTH bits are used. Bit 0 is high so UART TX idles high.
- HB_LOG2, 24, heartbeat half-period is 2^HB_LOG2 cycles (optional feature only).

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  synchronous active-low reset
- i_wb_adr  in  1  register select: 0 = DATA, 1 = MODE
- i_wb_dat  in  32  write data
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  bus cycle request
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  single-cycle acknowledge
- o_gpio  out  WIDTH  channel outputs
- o_heartbeat  out  1  heartbeat LED (optional feature)

Behaviour:
- Clock and reset: one clock, wb_clk. Reset is synchronous and active-low: wb_rst_n is sampled low at a rising edge of wb_clk.
- Reset values:
  - DATA = RESET_VAL[WIDTH-1:0]; prev_data = the same value.
  - MODE = 0 (all channels direct).
  - All stretch counters = 0; heartbeat counter = 0.
  - o_wb_ack = 0; o_wb_rdt = 0; o_heartbeat = 0.
  - o_gpio = RESET_VAL[WIDTH-1:0], visible from the first cycle after the reset edge.
- Bus handshake:
  - o_wb_ack <= i_wb_cyc & !o_wb_ack. Ack rises one cycle after cyc and is a one-cycle pulse.
  - The master drops cyc on ack. If cyc is held high, the block acks every second cycle.
- Write: on the edge where ack rises, if i_wb_we is set, the selected register <= i_wb_dat[WIDTH-1:0].
- Read: on the same edge, o_wb_rdt <= zero-extended DATA or MODE; bits above WIDTH read 0. DATA reads return the register, not o_gpio. o_wb_rdt holds until the next access.
- Edge detect:
  - Each cycle, prev_data <= DATA.
  - edge[i] = DATA[i] ^ prev_data[i]. A write of an unchanged value produces no edge.
- Direct mode (MODE[i] = 0):
  - o_gpio[i] = DATA[i], combinational from the flop. It changes in the cycle after the write edge.
  - The stretch counter is held at 0.
- Stretch mode (MODE[i] = 1):
  - An edge loads cnt[i] = 2^STRETCH_W-1.
  - Otherwise, if cnt[i] != 0, cnt[i] decrements.
  - o_gpio[i] = (cnt[i] != 0). It is high for exactly 2^STRETCH_W-1 cycles, starting the cycle after the edge is seen.
  - An edge arriving while the counter is running reloads it (retrigger); the counter saturates at 0.
- Mode switch:
  - Clearing MODE[i] mid-stretch zeroes cnt[i] on the same edge; o_gpio[i] follows DATA[i] at once.
  - Setting MODE[i] starts with cnt[i] = 0, so o_gpio[i] = 0 until the next edge.
- Reset mid-operation: in-flight acks and stretches are discarded; all state returns to the reset values above.
- Configurations with WIDTH > 32 are illegal; the block stops elaboration with $fatal.

Optional Feature:
- Macro: SERVANT_GPIO_HEARTBEAT_EN.
- Defined: a free-running HB_LOG2+1-bit counter; o_heartbeat = its MSB. It toggles every 2^HB_LOG2 cycles, and reset clears it.
- Undefined: o_heartbeat is tied to 0, no counter is built, and HB_LOG2 is ignored.

Decomposition:
- Package servant_gpio_pkg holds:
  - localparams ADR_DATA = 1'b0 and ADR_MODE = 1'b1;
  - MODE_DIRECT = 1'b0 and MODE_STRETCH = 1'b1;
  - MAX_WIDTH = 32.
- Sub-module servant_gpio_stretch, one instance per channel via generate.
  - Inputs: clk, rst_n, en (MODE bit), edge.
  - Output: active.
  - Owns the STRETCH_W-bit counter.
- Top level keeps the bus logic, DATA/MODE/prev_data registers, output mux and heartbeat.

Test Plan:
- Reset default: WIDTH=8, hold wb_rst_n low 3 cycles, then release → o_gpio=8'h01, o_wb_ack=0, o_heartbeat=0; a DATA read returns 32'h0000_0001.
- Handshake: cyc=1, we=1, adr=0, dat=32'hFFFF_FFA5 → ack exactly one cycle later for one cycle; o_gpio=8'hA5 the cycle after ack; a DATA read returns 32'h0000_00A5.
- Stretch, STRETCH_W=4:
  - set MODE=8'h02, then write DATA bit1 0→1 → o_gpio[1] high for exactly 15 cycles, then 0;
  - rewriting the same DATA → no pulse.
- Retrigger: STRETCH_W=4, toggle bit1 at pulse cycle 10 → o_gpio[1] stays high and falls 15 cycles after the second edge.
- Mode switch and reset:
  - clear MODE bit1 mid-pulse → o_gpio[1]=DATA[1] immediately;
  - assert wb_rst_n=0 during a pending ack → ack stays 0 and o_gpio returns to 8'h01.
- Heartbeat: with SERVANT_GPIO_HEARTBEAT_EN and HB_LOG2=3 → o_heartbeat toggles every 8 cycles; without the macro → constant 0.
